// File: rtl/fpu_iter_divsqrt.sv
// fpu_iter_divsqrt
// Multi-cycle mantissa unit for FDIV.S / FSQRT.S. Radix-2 restoring divide
// or square root, one result bit per clock, on mantissas including the
// hidden bit. Exponent/sign/rounding/special cases live outside this block.
//
// Handshake (responder side): the controller raises start and holds it high
// while the op is pending. A load happens on the first edge in IDLE with
// start=1. Dropping start during RUN aborts the op without a done pulse.
// done is a single-cycle pulse in the DONE state; result/sticky are valid
// then and hold until the next successful completion. DONE always moves to
// REARM, and REARM always moves to IDLE, so a back-to-back op loads two
// edges after the done cycle.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   start          level request from the FPU controller
//   op_sqrt        0 = a/b, 1 = sqrt(a); sampled at load
//   exp_odd        sqrt only: pre-shift radicand left by one; sampled at load
//   a_mant, b_mant operand mantissas (MW bits, hidden bit at MSB)
//   busy           high in RUN, DONE and REARM
//   done           one-cycle result-valid pulse
//   result         QW-bit quotient or root (int bit, MW-1 frac, guard, round)
//   sticky         final partial remainder is nonzero
//   dbg_state      current FSM state (IDLE=0, RUN=1, DONE=2, REARM=3)
module fpu_iter_divsqrt #(
  parameter int MW = 24,
  parameter int QW = MW + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          op_sqrt,
  input  logic          exp_odd,
  input  logic [MW-1:0] a_mant,
  input  logic [MW-1:0] b_mant,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] result,
  output logic          sticky,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(QW);
  localparam int XW = 2 * QW;
  localparam int RW = QW + 2;
  // Left shift that places the radicand so its root carries QW bits.
  localparam int XS = XW - MW - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    REARM = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] cnt_q;
  logic [RW-1:0] rem_q;
  logic [QW-1:0] quo_q;
  logic [XW-1:0] x_q;
  logic [MW-1:0] b_q;
  logic          sqrt_q;

  logic last_iter;
  assign last_iter = (cnt_q == CW'(QW - 1));

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN: begin
        if (!start)         state_next = IDLE;
        else if (last_iter) state_next = DONE;
      end
      DONE:    state_next = REARM;
      REARM:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // One iteration of either algorithm
  // ---------------------------------------------------------------------
  // Divide: partial remainder lives in rem_q[MW:0].
  logic [MW+1:0] d_diff;
  logic          d_ge;
  logic [MW:0]   d_rem;
  logic [RW-1:0] d_rem_next;

  // Sqrt: bring down the next two radicand bits, try subtracting 4*root+1.
  logic [RW-1:0] s_rs;
  logic [RW-1:0] s_trial;
  logic          s_ge;
  logic [RW-1:0] s_rem_next;

  logic          q_bit;
  logic [RW-1:0] rem_next;
  logic [QW-1:0] quo_next;
  logic [XW-1:0] x_load;

  always_comb begin
    d_diff     = {1'b0, rem_q[MW:0]} - {2'b00, b_q};
    d_ge       = ~d_diff[MW+1];
    d_rem      = d_ge ? d_diff[MW:0] : rem_q[MW:0];
    // After a step the remainder is below b < 2^MW, so the shift drops nothing.
    d_rem_next = {{(RW-MW-1){1'b0}}, d_rem[MW-1:0], 1'b0};

    s_rs       = {rem_q[QW-1:0], x_q[XW-1 -: 2]};
    s_trial    = {quo_q, 2'b01};
    s_ge       = (s_rs >= s_trial);
    s_rem_next = s_ge ? (s_rs - s_trial) : s_rs;

    q_bit    = sqrt_q ? s_ge : d_ge;
    rem_next = sqrt_q ? s_rem_next : d_rem_next;
    quo_next = {quo_q[QW-2:0], q_bit};

    x_load   = ({{(XW-MW){1'b0}}, a_mant} << XS) << exp_odd;
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      x_q    <= '0;
      b_q    <= '0;
      sqrt_q <= 1'b0;
      result <= '0;
      sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt_q  <= '0;
            quo_q  <= '0;
            b_q    <= b_mant;
            sqrt_q <= op_sqrt;
            x_q    <= x_load;
            rem_q  <= op_sqrt ? '0 : {{(RW-MW){1'b0}}, a_mant};
          end
        end
        RUN: begin
          if (start) begin
            cnt_q <= cnt_q + CW'(1);
            rem_q <= rem_next;
            quo_q <= quo_next;
            x_q   <= x_q << 2;
            if (last_iter) begin
              result <= quo_next;
              sticky <= (rem_next != '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_iter_divsqrt.sv
// Bench for fpu_iter_divsqrt: table of directed divide/sqrt vectors with
// hand-computed results, plus sequences for abort, back-to-back and
// asynchronous reset.
module tb_fpu_iter_divsqrt;

  localparam int MW = 24;
  localparam int QW = MW + 2;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          op_sqrt;
  logic          exp_odd;
  logic [MW-1:0] a_mant;
  logic [MW-1:0] b_mant;
  logic          busy;
  logic          done;
  logic [QW-1:0] result;
  logic          sticky;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  fpu_iter_divsqrt #(.MW(MW), .QW(QW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_sqrt   (op_sqrt),
    .exp_odd   (exp_odd),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .sticky    (sticky),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------
  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic          sq;
    logic          odd;
    logic [QW-1:0] exp_res;
    logic          exp_sticky;
  } vec_t;

  vec_t vecs[$];

  // Driver: one full op with start held until done. Returns nothing; checks
  // latency, result, sticky, done width, REARM and return to IDLE.
  task automatic run_op(input vec_t v, input string nm);
    int  lat;
    bit  seen;
    @(negedge clk);
    a_mant  = v.a;
    b_mant  = v.b;
    op_sqrt = v.sq;
    exp_odd = v.odd;
    start   = 1'b1;
    @(posedge clk);  // load edge E0
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      // operands must only matter at the load edge
      a_mant  = MW'($urandom_range(0, (1 << MW) - 1));
      b_mant  = MW'($urandom_range(0, (1 << MW) - 1));
      op_sqrt = ~v.sq;
      exp_odd = ~v.odd;
      if (done) seen = 1;
    end
    start = 1'b0;
    check({nm, " latency"}, 32'(lat), 32'(QW));
    check({nm, " result"}, 32'(result), 32'(v.exp_res));
    check({nm, " sticky"}, 32'(sticky), 32'(v.exp_sticky));
    @(posedge clk);
    @(negedge clk);
    check({nm, " done one cycle"}, 32'(done), 32'd0);
    check({nm, " rearm busy"}, 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({nm, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    vec_t v;

    // divide: 1.5/1, 1/1.5, max/max, 1/max, max/1
    vecs.push_back('{24'hC00000, 24'h800000, 1'b0, 1'b0, 26'h3000000, 1'b0});
    vecs.push_back('{24'h800000, 24'hC00000, 1'b0, 1'b0, 26'h1555555, 1'b1});
    vecs.push_back('{24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 26'h2000000, 1'b0});
    vecs.push_back('{24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 26'h1000001, 1'b1});
    vecs.push_back('{24'hFFFFFF, 24'h800000, 1'b0, 1'b0, 26'h3FFFFFC, 1'b0});
    // sqrt: 1, 2, 9/8*2 = 2.25, 196/128*2
    vecs.push_back('{24'h800000, 24'h000000, 1'b1, 1'b0, 26'h2000000, 1'b0});
    vecs.push_back('{24'h800000, 24'h000000, 1'b1, 1'b1, 26'h2D413CC, 1'b1});
    vecs.push_back('{24'h900000, 24'h000000, 1'b1, 1'b1, 26'h3000000, 1'b0});
    vecs.push_back('{24'hC40000, 24'h000000, 1'b1, 1'b1, 26'h3800000, 1'b0});

    start   = 1'b0;
    op_sqrt = 1'b0;
    exp_odd = 1'b0;
    a_mant  = '0;
    b_mant  = '0;
    reset   = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset sticky", 32'(sticky), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));
    // last vector left result=0x3800000, sticky=0

    // ---- abort at the 10th RUN cycle ----
    @(negedge clk);
    a_mant = 24'h800000; b_mant = 24'hC00000; op_sqrt = 1'b0; exp_odd = 1'b0;
    start  = 1'b1;
    @(posedge clk);  // E0
    seen = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen = 1;
    end
    start = 1'b0;  // inside the 10th RUN cycle
    @(posedge clk);
    @(negedge clk);
    if (done) seen = 1;
    check("abort state idle", 32'(dbg_state), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen = 1;
    end
    check("abort no done", 32'(seen), 32'd0);
    check("abort result held", 32'(result), 32'h3800000);
    check("abort sticky held", 32'(sticky), 32'd0);
    run_op(vecs[1], "after abort");

    // ---- back-to-back ----
    @(negedge clk);
    a_mant = 24'hC00000; b_mant = 24'h800000; op_sqrt = 1'b0; exp_odd = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done) seen = 1;
    end
    check("b2b first latency", 32'(lat), 32'(QW));
    check("b2b first result", 32'(result), 32'h3000000);
    @(posedge clk);
    @(negedge clk);
    check("b2b rearm state", 32'(dbg_state), 32'd3);
    a_mant = 24'h800000; b_mant = 24'hC00000;  // new operands during REARM
    lat = 0; seen = 0;
    while (!seen && lat < 60) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done) seen = 1;
    end
    start = 1'b0;
    // REARM edge already counted separately: 1 (IDLE) + 1 (load) + QW
    check("b2b second latency", 32'(lat), 32'(QW + 2));
    check("b2b second result", 32'(result), 32'h1555555);
    check("b2b second sticky", 32'(sticky), 32'd1);
    repeat (3) @(posedge clk);

    // ---- async reset mid-RUN ----
    @(negedge clk);
    v = vecs[7];
    a_mant = v.a; b_mant = v.b; op_sqrt = v.sq; exp_odd = v.odd;
    start  = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst done", 32'(done), 32'd0);
    check("arst result", 32'(result), 32'd0);
    check("arst sticky", 32'(sticky), 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_op(vecs[6], "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
